bmc_tx: RTL and testbench

- USB-PD BMC transmitter on the digital side of the anatop_1127a0 PHY.
- Drives the PHY's TX_EN/TX_DAT inputs; it is the transmit counterpart of the RX_D_PK/RX_SQL receive path.
- Frame sequence: preamble, 4b5b-encoded items from a valid/ready stream, then a driven-low tail.
- Sits between the PD protocol layer and anatop_1127a0.

---
 rtl/bmc_tx_pkg.sv | 46 ++++
 rtl/bmc_tx_crc32.sv | 35 +++
 rtl/bmc_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_bmc_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bmc_tx_pkg.sv
// Shared types and constants for the USB-PD BMC transmitter (4b5b table, K-codes, FSM states, CRC-32).
package bmc_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_CRC,
        ST_EOP,
        ST_TAIL
    } state_e;

    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC2 = 5'b10001;
    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_EOP   = 5'b01101;

    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
        logic [4:0] sym;
        case (nib)
            4'h0: sym = 5'b11110;
            4'h1: sym = 5'b01001;
            4'h2: sym = 5'b10100;
            4'h3: sym = 5'b10101;
            4'h4: sym = 5'b01010;
            4'h5: sym = 5'b01011;
            4'h6: sym = 5'b01110;
            4'h7: sym = 5'b01111;
            4'h8: sym = 5'b10010;
            4'h9: sym = 5'b10011;
            4'hA: sym = 5'b10110;
            4'hB: sym = 5'b10111;
            4'hC: sym = 5'b11010;
            4'hD: sym = 5'b11011;
            4'hE: sym = 5'b11100;
            default: sym = 5'b11101;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/bmc_tx_crc32.sv
// Byte-wide reflected CRC-32 accumulator with clear and update strobes (used only with BMC_TX_CRC_EN).
module bmc_tx_crc32
    import bmc_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstz_i,
    input  logic        clr_i,
    input  logic        upd_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q ^ {24'd0, byte_i};
        for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY_REFL) : (crc_d >> 1);
        end
    end

    always_ff @(posedge clk_i or negedge rstz_i) begin
        if (!rstz_i) begin
            crc_q <= CRC_INIT;
        end else if (clr_i) begin
            crc_q <= CRC_INIT;
        end else if (upd_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/bmc_tx.sv
// USB-PD BMC transmitter: preamble, 4b5b items from a valid/ready stream, low tail.
// Define BMC_TX_CRC_EN to append CRC-32 and EOP automatically after the last item.
module bmc_tx
    import bmc_tx_pkg::*;
#(
    parameter int HALF_UI       = 20,
    parameter int PREAMBLE_BITS = 64,
    parameter int HOLD_UI       = 1
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       i_start,
    input  logic       i_vld,
    input  logic       i_kcode,
    input  logic [7:0] i_byte,
    input  logic       i_last,
    output logic       o_rdy,
    output logic       o_tx_en,
    output logic       o_tx_dat,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_underrun
);

    localparam int CNT_W = $clog2(HALF_UI + 1);
    localparam int BIT_W = $clog2(PREAMBLE_BITS + HOLD_UI + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             half_q, line_q, tx_en_q, done_q, underrun_q, last_q;
    logic [BIT_W-1:0] bit_q;
    logic [3:0]       left_q, nxt_len_q;
    logic             nxt_vld_q, nxt_last_q;
    logic [9:0]       nxt_sym_q, sh_q;

    logic       tick, mid, boundary, cur_bit, pre_end, req_win, window, hs;
    logic       load_nxt, underrun, last_end, shift, start_go;
    logic       ld, ld_last, to_tail;
    logic [9:0] in_sym, ld_sym;
    logic [3:0] in_len, ld_len;
    state_e     ld_state;

    assign tick     = (cnt_q == CNT_W'(HALF_UI - 1));
    assign mid      = tick && !half_q;
    assign boundary = tick && half_q;
    assign cur_bit  = (state_q == ST_PRE) ? bit_q[0] : sh_q[0];
    assign pre_end  = (state_q == ST_PRE) && (bit_q == BIT_W'(PREAMBLE_BITS - 1));
    // The next item is requested only while the preamble or a non-final item is ending.
    assign req_win  = pre_end || ((state_q == ST_DATA) && (left_q == 4'd1) && !last_q);
    assign window   = half_q && req_win && !nxt_vld_q;
    assign hs       = i_vld && window;
    assign load_nxt = boundary && req_win && (nxt_vld_q || hs);
    assign underrun = boundary && req_win && !(nxt_vld_q || hs);
    assign last_end = boundary && (state_q == ST_DATA) && (left_q == 4'd1) && last_q;
    assign shift    = boundary && (left_q > 4'd1) &&
                      (state_q == ST_DATA || state_q == ST_CRC || state_q == ST_EOP);
    assign start_go = (state_q == ST_IDLE) && i_start;

    assign in_sym = i_kcode ? {5'd0, i_byte[4:0]} : {enc4b5b(i_byte[7:4]), enc4b5b(i_byte[3:0])};
    assign in_len = i_kcode ? 4'd5 : 4'd10;

`ifdef BMC_TX_CRC_EN
    logic [1:0]  crc_idx_q, crc_sel;
    logic [31:0] crc_raw, crc_fin;
    logic [7:0]  crc_byte;
    logic        crc_next, eop_start, eop_end;

    assign crc_next  = boundary && (state_q == ST_CRC) && (left_q == 4'd1) && (crc_idx_q != 2'd3);
    assign eop_start = boundary && (state_q == ST_CRC) && (left_q == 4'd1) && (crc_idx_q == 2'd3);
    assign eop_end   = boundary && (state_q == ST_EOP) && (left_q == 4'd1);
    assign crc_sel   = last_end ? 2'd0 : crc_idx_q + 2'd1;
    assign crc_fin   = ~crc_raw;
    assign crc_byte  = crc_fin[{crc_sel, 3'b000} +: 8];

    bmc_tx_crc32 u_crc (
        .clk_i  (clk),
        .rstz_i (rstz),
        .clr_i  (start_go),
        .upd_i  (hs && !i_kcode),
        .byte_i (i_byte),
        .crc_o  (crc_raw)
    );

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            crc_idx_q <= 2'd0;
        end else if (last_end) begin
            crc_idx_q <= 2'd0;
        end else if (crc_next) begin
            crc_idx_q <= crc_idx_q + 2'd1;
        end
    end
`endif

    always_comb begin
        ld       = 1'b0;
        ld_sym   = '0;
        ld_len   = 4'd0;
        ld_last  = 1'b1;
        ld_state = ST_DATA;
        to_tail  = underrun;
        if (load_nxt) begin
            ld      = 1'b1;
            ld_sym  = nxt_vld_q ? nxt_sym_q  : in_sym;
            ld_len  = nxt_vld_q ? nxt_len_q  : in_len;
            ld_last = nxt_vld_q ? nxt_last_q : i_last;
        end
`ifdef BMC_TX_CRC_EN
        else if (last_end || crc_next) begin
            ld       = 1'b1;
            ld_sym   = {enc4b5b(crc_byte[7:4]), enc4b5b(crc_byte[3:0])};
            ld_len   = 4'd10;
            ld_state = ST_CRC;
        end else if (eop_start) begin
            ld       = 1'b1;
            ld_sym   = {5'd0, K_EOP};
            ld_len   = 4'd5;
            ld_state = ST_EOP;
        end
        to_tail = underrun || eop_end;
`else
        to_tail = underrun || last_end;
`endif
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            line_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            last_q     <= 1'b0;
            bit_q      <= '0;
            left_q     <= 4'd0;
            nxt_len_q  <= 4'd0;
            nxt_vld_q  <= 1'b0;
            nxt_last_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (hs) begin
                nxt_vld_q  <= 1'b1;
                nxt_last_q <= i_last;
                nxt_len_q  <= in_len;
            end
            if (state_q != ST_IDLE) begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (tick) half_q <= ~half_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q   <= ST_PRE;
                        tx_en_q   <= 1'b1;
                        line_q    <= 1'b1;
                        cnt_q     <= '0;
                        half_q    <= 1'b0;
                        bit_q     <= '0;
                        last_q    <= 1'b0;
                        nxt_vld_q <= 1'b0;
                    end
                end
                ST_TAIL: begin
                    if (boundary) begin
                        if (bit_q == BIT_W'(HOLD_UI - 1)) begin
                            state_q <= ST_IDLE;
                            tx_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (mid && cur_bit) line_q <= ~line_q;
                    if (boundary) begin
                        if (to_tail) begin
                            state_q    <= ST_TAIL;
                            line_q     <= 1'b0;
                            bit_q      <= '0;
                            underrun_q <= underrun;
                        end else begin
                            line_q <= ~line_q;
                            if (state_q == ST_PRE && !pre_end) bit_q <= bit_q + 1'b1;
                            if (ld) begin
                                state_q <= ld_state;
                                left_q  <= ld_len;
                                last_q  <= ld_last;
                            end else begin
                                left_q <= left_q - 4'd1;
                            end
                            if (load_nxt) nxt_vld_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Symbol shift data carries no reset; it is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (hs) nxt_sym_q <= in_sym;
        if (ld) begin
            sh_q <= ld_sym;
        end else if (shift) begin
            sh_q <= sh_q >> 1;
        end
    end

    assign o_rdy      = window;
    assign o_tx_en    = tx_en_q;
    assign o_tx_dat   = line_q & tx_en_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_bmc_tx.sv
// Randomized self-checking bench for bmc_tx against a bit-list / half-UI level reference model.
module tb_bmc_tx;

    localparam int HALF_UI = 2;
    localparam int PRE_B   = 4;
    localparam int HOLD_UI = 1;
`ifdef BMC_TX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    localparam logic [4:0] ENC [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                        5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                        5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                        5'b11010, 5'b11011, 5'b11100, 5'b11101};

    logic       clk = 1'b0, rstz = 1'b0, i_start = 1'b0, i_vld = 1'b0, i_kcode = 1'b0, i_last = 1'b0;
    logic [7:0] i_byte = 8'd0;
    logic       o_rdy, o_tx_en, o_tx_dat, o_busy, o_done, o_underrun;

    int n_checks = 0, n_errors = 0;
    logic       it_k [16];
    logic [7:0] it_b [16];
    int         bits [$];
    logic       exp_lvl [$];

    bmc_tx #(.HALF_UI(HALF_UI), .PREAMBLE_BITS(PRE_B), .HOLD_UI(HOLD_UI)) dut (
        .clk(clk), .rstz(rstz), .i_start(i_start), .i_vld(i_vld), .i_kcode(i_kcode),
        .i_byte(i_byte), .i_last(i_last), .o_rdy(o_rdy), .o_tx_en(o_tx_en),
        .o_tx_dat(o_tx_dat), .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_item(input logic k, input logic [7:0] b);
        logic [4:0] lo, hi;
        if (k) begin
            for (int j = 0; j < 5; j++) bits.push_back(int'(b[j]));
        end else begin
            lo = ENC[b[3:0]];
            hi = ENC[b[7:4]];
            for (int j = 0; j < 5; j++) bits.push_back(int'(lo[j]));
            for (int j = 0; j < 5; j++) bits.push_back(int'(hi[j]));
        end
    endtask

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            if (!it_k[i]) begin
                c = c ^ {24'd0, it_b[i]};
                for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Expected line level per clock cycle from the first TX_EN cycle up to the done cycle.
    task automatic build_exp(input int n_sup, input bit with_crc);
        logic lvl = 1'b0;
        logic [31:0] c;
        logic [4:0] eop = 5'b01101;
        bits.delete();
        exp_lvl.delete();
        for (int p = 0; p < PRE_B; p++) bits.push_back(p % 2);
        for (int i = 0; i < n_sup; i++) push_item(it_k[i], it_b[i]);
        if (with_crc) begin
            c = ref_crc(n_sup);
            for (int j = 0; j < 4; j++) push_item(1'b0, c[8*j +: 8]);
            for (int j = 0; j < 5; j++) bits.push_back(int'(eop[j]));
        end
        foreach (bits[i]) begin
            lvl = ~lvl;
            for (int h = 0; h < HALF_UI; h++) exp_lvl.push_back(lvl);
            if (bits[i] != 0) lvl = ~lvl;
            for (int h = 0; h < HALF_UI; h++) exp_lvl.push_back(lvl);
        end
        for (int h = 0; h < 2 * HOLD_UI * HALF_UI; h++) exp_lvl.push_back(1'b0);
    endtask

    // mode 0: i_vld held high whenever an item is pending; mode 1: random vld with late acceptance.
    task automatic run_frame(input string name, input int n_sup, input bit is_last, input int mode);
        int   idx = 0, cyc = 0, hs_cnt = 0, und_cnt = 0, und_at = -1, rdy_late = 0;
        bit   hs_p = 1'b0, waited = 1'b0, done = 1'b0, last_taken = 1'b0, last_drv = 1'b0;
        logic cap [$];
        int   n_cmp;
        build_exp(n_sup, is_last && CRC_ON);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({name, " tx_en_rise"}, o_tx_en, 1'b1);
        check({name, " busy_rise"}, o_busy, 1'b1);
        while (!done && cyc < 2000) begin
            if (hs_p) begin
                hs_cnt++;
                if (last_drv) last_taken = 1'b1;
                idx++;
                waited = 1'b0;
            end
            if (o_done) begin
                done = 1'b1;
                check({name, " done_tx_en"}, o_tx_en, 1'b0);
                check({name, " done_tx_dat"}, o_tx_dat, 1'b0);
            end else begin
                cap.push_back(o_tx_dat);
                if (o_underrun) begin
                    und_cnt++;
                    und_at = cap.size() - 1;
                end
                if (last_taken && o_rdy) rdy_late++;
            end
            i_start = (cyc < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (idx < n_sup) begin
                i_kcode = it_k[idx];
                i_byte  = it_b[idx];
                i_last  = is_last && (idx == n_sup - 1);
                if (mode == 0) i_vld = 1'b1;
                else if (o_rdy && !waited && $urandom_range(0, 1) == 1) begin
                    i_vld = 1'b0;
                    waited = 1'b1;
                end else if (o_rdy) i_vld = 1'b1;
                else i_vld = 1'($urandom_range(0, 1));
            end else begin
                i_vld  = is_last ? 1'($urandom_range(0, 1)) : 1'b0;
                i_last = 1'b0;
                i_byte = 8'($urandom);
            end
            last_drv = i_last;
            hs_p = i_vld && o_rdy;
            cyc++;
            if (!done) @(negedge clk);
        end
        i_start = 1'b0;
        i_vld   = 1'b0;
        i_last  = 1'b0;
        check({name, " done_seen"}, done, 1'b1);
        check({name, " frame_len"}, cap.size(), exp_lvl.size());
        n_cmp = (cap.size() < exp_lvl.size()) ? cap.size() : exp_lvl.size();
        for (int i = 0; i < n_cmp; i++) check($sformatf("%s line[%0d]", name, i), cap[i], exp_lvl[i]);
        check({name, " handshakes"}, hs_cnt, n_sup);
        check({name, " underrun_cnt"}, und_cnt, is_last ? 0 : 1);
        if (!is_last) check({name, " underrun_at"}, und_at, exp_lvl.size() - 2 * HOLD_UI * HALF_UI);
        check({name, " rdy_after_last"}, rdy_late, 0);
        @(negedge clk);
        check({name, " idle_busy"}, o_busy, 1'b0);
        check({name, " idle_tx_en"}, o_tx_en, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst tx_en", o_tx_en, 1'b0);
        check("rst tx_dat", o_tx_dat, 1'b0);
        check("rst busy", o_busy, 1'b0);
        check("rst done", o_done, 1'b0);
        check("rst underrun", o_underrun, 1'b0);
        check("rst rdy", o_rdy, 1'b0);
        rstz = 1'b1;

        it_k[0] = 1'b1; it_b[0] = 8'b101_11000;
        run_frame("sync1", 1, 1'b1, 0);

        it_k[0] = 1'b0; it_b[0] = 8'h5A;
        run_frame("d5a", 1, 1'b1, 0);

        run_frame("und_pre", 0, 1'b0, 0);

        it_k[0] = 1'b1; it_b[0] = 8'h18;
        it_k[1] = 1'b0; it_b[1] = 8'h3C;
        it_k[2] = 1'b0; it_b[2] = 8'hF0;
        it_k[3] = 1'b1; it_b[3] = 8'hED;
        run_frame("b2b", 4, 1'b1, 0);

        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                it_k[i] = 1'($urandom_range(0, 1));
                it_b[i] = 8'($urandom);
            end
            run_frame($sformatf("rnd%0d", f), n, (f % 4) != 3, $urandom_range(0, 1));
        end

        // Abort a frame in the middle of a data item.
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_vld = 1'b1; i_kcode = 1'b0; i_byte = 8'hA5; i_last = 1'b0;
        repeat (4 * PRE_B * HALF_UI + 6) @(negedge clk);
        rstz = 1'b0;
        #1;
        check("arst tx_en", o_tx_en, 1'b0);
        check("arst tx_dat", o_tx_dat, 1'b0);
        check("arst busy", o_busy, 1'b0);
        i_vld = 1'b0;
        @(negedge clk);
        rstz = 1'b1;
        it_k[0] = 1'b0; it_b[0] = 8'h96;
        run_frame("post_rst", 1, 1'b1, 1);

`ifdef BMC_TX_CRC_EN
        it_k[0] = 1'b0; it_b[0] = 8'h01;
        it_k[1] = 1'b1; it_b[1] = 8'h11;
        it_k[2] = 1'b0; it_b[2] = 8'h02;
        run_frame("crc", 3, 1'b1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
